// File: rtl/placar_shot_display_if.sv
// Shot-clock display bus: the count coming in, and the display and buzzer
// pins going out.
interface placar_shot_display_if;
   logic [4:0] cronometro;
   logic [6:0] seg;
   logic [1:0] an;
   logic       buzzer;
   logic       expirado;

   // The master drives the count and watches the pins.
   modport master (output cronometro, input seg, input an, input buzzer, input expirado);
   // The display block takes in the count and drives the pins.
   modport slave  (input cronometro, output seg, output an, output buzzer, output expirado);
endinterface

// File: rtl/placar_shot_display.sv
// Shot-clock display:
// - resynchronises and filters the asynchronous 5-bit count
// - decodes it to two multiplexed active-low 7-segment digits
// - sounds the buzzer when the count expires
// STABLE_CYCLES must be at least 2.
module placar_shot_display #(
   parameter int STABLE_CYCLES = 4,
   parameter int SCAN_DIV      = 50000,
   parameter int BUZZ_CYCLES   = 50000000,
   parameter int BLINK_DIV     = 12500000
) (
   input  logic                  clk,
   input  logic                  reset,
   placar_shot_display_if.slave  bus
);

   localparam int STAB_W  = $clog2(STABLE_CYCLES + 1);
   localparam int SCAN_W  = $clog2(SCAN_DIV + 1);
   localparam int BUZZ_W  = $clog2(BUZZ_CYCLES + 1);
   localparam int BLINK_W = $clog2(2 * BLINK_DIV + 1);

   // The cycle where s2 first differs from cand already holds the first new
   // sample, so the load fires once stab has counted STABLE_CYCLES-2 matches.
   localparam logic [STAB_W-1:0]  STAB_LOAD  = STAB_W'(STABLE_CYCLES - 2);
   localparam logic [STAB_W-1:0]  STAB_MAX   = STAB_W'(STABLE_CYCLES - 1);
   localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
   localparam logic [BUZZ_W-1:0]  BUZZ_LAST  = BUZZ_W'(BUZZ_CYCLES - 1);
   localparam logic [BLINK_W-1:0] BLINK_HALF = BLINK_W'(BLINK_DIV);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(2 * BLINK_DIV - 1);

   localparam logic [1:0] ST_WAIT_LOAD = 2'd0;
   localparam logic [1:0] ST_ARMED     = 2'd1;
   localparam logic [1:0] ST_BUZZ      = 2'd2;
   localparam logic [1:0] ST_EXPIRED   = 2'd3;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   logic [4:0]         s1_q, s1_d, s2_q, s2_d, cand_q, cand_d;
   logic [STAB_W-1:0]  stab_q, stab_d;
   logic [4:0]         count_q, count_d, prev_q, prev_d;
   logic [SCAN_W-1:0]  scan_q, scan_d;
   logic               sel_q, sel_d;
   logic [BLINK_W-1:0] blink_q, blink_d;
   logic [BUZZ_W-1:0]  buzz_q, buzz_d;
   logic [1:0]         state_q, state_d;
   logic [6:0]         seg_q, seg_d;
   logic [1:0]         an_q, an_d;
   logic               buzzer_q, buzzer_d, expirado_q, expirado_d;

   logic [3:0]         units_c, tens_c;
   logic               tens_blank_c, dash_c;

   // Active-low segment pattern {g,f,e,d,c,b,a} for one decimal digit.
   function automatic logic [6:0] seg_of(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   // Two-flop resync, then a glitch filter that only accepts a held value.
   always_comb begin
      s1_d    = bus.cronometro;
      s2_d    = s1_q;
      cand_d  = s2_q;
      count_d = count_q;
      prev_d  = prev_q;
      if (s2_q != cand_q)
         stab_d = '0;
      else if (stab_q == STAB_MAX)
         stab_d = stab_q;
      else
         stab_d = stab_q + 1'b1;
      if ((s2_q == cand_q) && (stab_q >= STAB_LOAD) && (cand_q != count_q)) begin
         count_d = cand_q;
         prev_d  = count_q;
      end
   end

   // Split the accepted count into tens and units; out-of-range shows dashes.
   always_comb begin
      units_c      = 4'(count_q);
      tens_c       = 4'd0;
      tens_blank_c = 1'b1;
      dash_c       = 1'b0;
      if (count_q >= 5'd25) begin
         dash_c = 1'b1;
      end else if (count_q >= 5'd20) begin
         tens_c       = 4'd2;
         tens_blank_c = 1'b0;
         units_c      = 4'(count_q - 5'd20);
      end else if (count_q >= 5'd10) begin
         tens_c       = 4'd1;
         tens_blank_c = 1'b0;
         units_c      = 4'(count_q - 5'd10);
      end
   end

   // Expiry FSM: arm on a loaded count, buzz only on a genuine 1 -> 0 step.
   always_comb begin
      state_d = state_q;
      buzz_d  = buzz_q;
      case (state_q)
         ST_WAIT_LOAD: begin
            if (count_q != 5'd0) state_d = ST_ARMED;
         end
         ST_ARMED: begin
            if (count_q == 5'd0) begin
               buzz_d  = '0;
               state_d = (prev_q == 5'd1) ? ST_BUZZ : ST_WAIT_LOAD;
            end
         end
         ST_BUZZ: begin
            if (count_q != 5'd0)
               state_d = ST_ARMED;
            else if (buzz_q == BUZZ_LAST)
               state_d = ST_EXPIRED;
            else
               buzz_d = buzz_q + 1'b1;
         end
         ST_EXPIRED: begin
            if (count_q != 5'd0) state_d = ST_ARMED;
         end
         default: state_d = ST_WAIT_LOAD;
      endcase
      buzzer_d   = (state_d == ST_BUZZ);
      expirado_d = (state_d == ST_BUZZ) || (state_d == ST_EXPIRED);
   end

   // Digit scan, expiry blink and the registered segment/anode drive.
   always_comb begin
      if (scan_q == SCAN_LAST) begin
         scan_d = '0;
         sel_d  = ~sel_q;
      end else begin
         scan_d = scan_q + 1'b1;
         sel_d  = sel_q;
      end
      if (state_q != ST_EXPIRED)
         blink_d = '0;
      else if (blink_q == BLINK_LAST)
         blink_d = '0;
      else
         blink_d = blink_q + 1'b1;

      an_d = sel_q ? 2'b01 : 2'b10;
      if ((state_q == ST_EXPIRED) && (blink_q >= BLINK_HALF))
         seg_d = SEG_BLANK;
      else if (dash_c)
         seg_d = SEG_DASH;
      else if (!sel_q)
         seg_d = seg_of(units_c);
      else if (tens_blank_c)
         seg_d = SEG_BLANK;
      else
         seg_d = seg_of(tens_c);
   end

   // Input path registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q    <= '0;
         s2_q    <= '0;
         cand_q  <= '0;
         stab_q  <= '0;
         count_q <= '0;
         prev_q  <= '0;
      end else begin
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         cand_q  <= cand_d;
         stab_q  <= stab_d;
         count_q <= count_d;
         prev_q  <= prev_d;
      end
   end

   // Control and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_WAIT_LOAD;
         buzz_q     <= '0;
         scan_q     <= '0;
         sel_q      <= 1'b0;
         blink_q    <= '0;
         seg_q      <= SEG_BLANK;
         an_q       <= 2'b11;
         buzzer_q   <= 1'b0;
         expirado_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         buzz_q     <= buzz_d;
         scan_q     <= scan_d;
         sel_q      <= sel_d;
         blink_q    <= blink_d;
         seg_q      <= seg_d;
         an_q       <= an_d;
         buzzer_q   <= buzzer_d;
         expirado_q <= expirado_d;
      end
   end

   assign bus.seg      = seg_q;
   assign bus.an       = an_q;
   assign bus.buzzer   = buzzer_q;
   assign bus.expirado = expirado_q;

endmodule

// File: tb/tb_placar_shot_display.sv
// Bench for the shot-clock display: vector table, hand-written expiry
// sequences and randomly held counts against a decimal reference model.
module tb_placar_shot_display;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   placar_shot_display_if bus ();

   placar_shot_display #(
      .STABLE_CYCLES(4),
      .SCAN_DIV(4),
      .BUZZ_CYCLES(10),
      .BLINK_DIV(8)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [4:0] cron;
      logic [6:0] units;
      logic [6:0] tens;
   } vec_t;

   vec_t tbl [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference decode from decimal arithmetic on the count.
   function automatic logic [6:0] digit_seg(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [6:0] model_seg(input int v, input logic [1:0] an_sel);
      if (v > 24) return 7'b0111111;
      if (an_sel == 2'b10) return digit_seg(v % 10);
      if (v / 10 == 0) return 7'b1111111;
      return digit_seg(v / 10);
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [4:0] v);
      bus.cronometro = v;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic check_display(input string name, input int v, input int n);
      int bad_an = 0, bad_seg = 0, bad_bz = 0;
      for (int i = 0; i < n; i++) begin
         if (!(bus.an == 2'b01 || bus.an == 2'b10)) bad_an++;
         if (bus.seg !== model_seg(v, bus.an)) bad_seg++;
         if (bus.buzzer !== 1'b0 || bus.expirado !== 1'b0) bad_bz++;
         tick();
      end
      check({name, "_an"}, 32'(bad_an), 32'd0);
      check({name, "_seg"}, 32'(bad_seg), 32'd0);
      check({name, "_buzz"}, 32'(bad_bz), 32'd0);
   endtask

   task automatic wait_buzz(input string name);
      bit seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         if (bus.buzzer === 1'b1) seen = 1'b1;
         else tick();
      end
      check(name, 32'(seen), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [1:0] an_prev;
      int hi, bad, seen16;
      logic [6:0] exp_seg;
      logic [4:0] rv;

      tbl[0] = '{5'd24, 7'b0011001, 7'b0100100};
      tbl[1] = '{5'd23, 7'b0110000, 7'b0100100};
      tbl[2] = '{5'd9,  7'b0010000, 7'b1111111};
      tbl[3] = '{5'd10, 7'b1000000, 7'b1111001};
      tbl[4] = '{5'd19, 7'b0010000, 7'b1111001};
      tbl[5] = '{5'd20, 7'b1000000, 7'b0100100};
      tbl[6] = '{5'd27, 7'b0111111, 7'b0111111};
      tbl[7] = '{5'd31, 7'b0111111, 7'b0111111};
      tbl[8] = '{5'd0,  7'b1000000, 7'b1111111};
      tbl[9] = '{5'd5,  7'b0010010, 7'b1111111};

      // Reset state, then latency of a freshly held 24.
      do_reset(5'd24);
      check("rst_seg", 32'(bus.seg), 32'h7F);
      check("rst_an", 32'(bus.an), 32'd3);
      check("rst_buzzer", 32'(bus.buzzer), 32'd0);
      check("rst_expirado", 32'(bus.expirado), 32'd0);
      repeat (6) tick();
      // count_q takes 24 on edge 6; the display still shows the old count.
      check("lat_edge6", 32'(bus.seg), 32'(model_seg(0, bus.an)));
      tick();
      check("lat_edge7", 32'(bus.seg), 32'(model_seg(24, bus.an)));
      for (int k = 0; k < 3; k++) begin
         an_prev = bus.an;
         repeat (4) tick();
         check("scan_toggle", 32'(bus.an ^ an_prev), 32'd3);
      end
      $display("txn latency24 done");

      // Table of held counts.
      for (int i = 0; i < 10; i++) begin
         bus.cronometro = tbl[i].cron;
         repeat (12) tick();
         bad = 0;
         for (int c = 0; c < 8; c++) begin
            if (bus.an == 2'b10) exp_seg = tbl[i].units;
            else if (bus.an == 2'b01) exp_seg = tbl[i].tens;
            else exp_seg = 7'bxxxxxxx;
            if (bus.seg !== exp_seg) bad++;
            tick();
         end
         check("table_seg", 32'(bad), 32'd0);
         $display("txn table[%0d] cron=%0d", i, tbl[i].cron);
      end

      // 24 -> 23 with a two-cycle glitch to 16 that must be filtered out.
      bus.cronometro = 5'd24;
      repeat (12) tick();
      bus.cronometro = 5'd16;
      tick();
      tick();
      bus.cronometro = 5'd23;
      seen16 = 0;
      for (int c = 0; c < 16; c++) begin
         if (bus.seg === model_seg(16, bus.an)) seen16++;
         tick();
      end
      check("glitch_16_seen", 32'(seen16), 32'd0);
      check_display("glitch_final23", 23, 8);
      $display("txn glitch done");

      // 1 -> 0: full buzz, then blinking expired display.
      bus.cronometro = 5'd1;
      repeat (12) tick();
      bus.cronometro = 5'd0;
      wait_buzz("buzz_start");
      hi = 0;
      bad = 0;
      while (bus.buzzer === 1'b1 && hi < 30) begin
         hi++;
         if (bus.expirado !== 1'b1) bad++;
         tick();
      end
      check("buzz_len", 32'(hi), 32'd10);
      check("buzz_expirado", 32'(bad), 32'd0);
      // Expired state begins as the buzzer drops; the registered display
      // shows the on phase for one extra sample, then 8 blank, then on again.
      bad = 0;
      for (int i = 0; i < 25; i++) begin
         if (i >= 9 && i < 17) exp_seg = 7'b1111111;
         else exp_seg = model_seg(0, bus.an);
         if (bus.seg !== exp_seg) bad++;
         if (bus.expirado !== 1'b1 || bus.buzzer !== 1'b0) bad++;
         tick();
      end
      check("blink_pattern", 32'(bad), 32'd0);
      $display("txn expire_blink done");

      // Reload during buzz beats the buzzer.
      bus.cronometro = 5'd1;
      repeat (12) tick();
      check("rearm_expirado", 32'(bus.expirado), 32'd0);
      bus.cronometro = 5'd0;
      wait_buzz("reload_buzz_start");
      bus.cronometro = 5'd24;
      hi = 0;
      while (bus.buzzer === 1'b1 && hi < 30) begin
         hi++;
         tick();
      end
      check("reload_buzz_len", 32'(hi), 32'd7);
      check("reload_expirado", 32'(bus.expirado), 32'd0);
      repeat (3) tick();
      check("reload_armed", 32'({bus.buzzer, bus.expirado}), 32'd0);
      $display("txn reload done");

      // Cleared counter (no 1 -> 0 step) never buzzes.
      do_reset(5'd0);
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         if (bus.buzzer !== 1'b0 || bus.expirado !== 1'b0) bad++;
         tick();
      end
      check("idle_zero_nobuzz", 32'(bad), 32'd0);
      bus.cronometro = 5'd24;
      repeat (12) tick();
      bus.cronometro = 5'd0;
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         if (bus.buzzer !== 1'b0 || bus.expirado !== 1'b0) bad++;
         tick();
      end
      check("clear_24_nobuzz", 32'(bad), 32'd0);
      check_display("clear_24_display", 0, 20);
      $display("txn no_buzz done");

      // Reset in the middle of a buzz.
      bus.cronometro = 5'd24;
      repeat (12) tick();
      bus.cronometro = 5'd1;
      repeat (12) tick();
      bus.cronometro = 5'd0;
      wait_buzz("midbuzz_start");
      tick();
      tick();
      reset = 1'b1;
      tick();
      check("midbuzz_rst_buzzer", 32'(bus.buzzer), 32'd0);
      check("midbuzz_rst_an", 32'(bus.an), 32'd3);
      check("midbuzz_rst_seg", 32'(bus.seg), 32'h7F);
      check("midbuzz_rst_expirado", 32'(bus.expirado), 32'd0);
      reset = 1'b0;
      $display("txn reset_midbuzz done");

      // Randomly held non-zero counts against the decimal model.
      for (int i = 0; i < 24; i++) begin
         rv = 5'($urandom_range(1, 31));
         bus.cronometro = rv;
         repeat (12) tick();
         check_display("rand", int'(rv), 8);
         $display("txn rand[%0d] cron=%0d", i, rv);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
